// File: rtl/mms_pkg.sv
// Shared types and constants for the frame min/max sequencer.
package mms_pkg;

  // Sample width in bits
  localparam int DW = 8;

  // Extreme selection: 0 picks the maximum, 1 picks the minimum
  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mms_frame_ctrl_if.sv
// Sample stream and control/result bundle between a sample source and the
// frame controller.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on controller state, never
// on in_valid. The source may raise or drop in_valid freely; while in_valid
// is high, in_data must be stable. start/sel are single-cycle requests that
// are honoured only while busy is low. out_valid is a one-cycle strobe and
// result holds its value until the next frame completes.
interface mms_frame_ctrl_if;
  import mms_pkg::*;

  logic          start;
  logic          sel;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] result;

  // Source / testbench side
  modport master (
    output start, sel, in_valid, in_data,
    input  in_ready, busy, out_valid, result
  );

  // Controller side
  modport slave (
    input  start, sel, in_valid, in_data,
    output in_ready, busy, out_valid, result
  );
endinterface

// File: rtl/mms_cmp4.sv
// Combinational 4-input max/min tree: two pairwise compares, then a final
// compare. Ties return the shared value, so operand order never matters.
module mms_cmp4
  import mms_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic [DW-1:0] d_i,
  input  logic          sel_i,
  output logic [DW-1:0] y_o
);

  logic [DW-1:0] ab;
  logic [DW-1:0] cd;

  // Unsigned pairwise reduction toward the selected extreme
  always_comb begin
    if (sel_i == SEL_MAX) begin
      ab  = (a_i >= b_i) ? a_i : b_i;
      cd  = (c_i >= d_i) ? c_i : d_i;
      y_o = (ab >= cd) ? ab : cd;
    end else begin
      ab  = (a_i <= b_i) ? a_i : b_i;
      cd  = (c_i <= d_i) ? c_i : d_i;
      y_o = (ab <= cd) ? ab : cd;
    end
  end

endmodule

// File: rtl/mms_frame_ctrl.sv
// Frame sequencer: gathers FRAME_LEN samples four at a time, reduces each
// group through the shared comparator, folds group results into a running
// accumulator and strobes the frame-wide extreme.
module mms_frame_ctrl
  import mms_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int GRP_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  mms_frame_ctrl_if.slave    bus,
  output state_t             dbg_state_o
);

  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(FRAME_LEN / 4 - 1);

  state_t        state_q, state_d;
  logic          sel_q;
  logic [GRP_W-1:0] grp_cnt_q;
  logic [1:0]    beat_cnt_q;
  logic [DW-1:0] buf_q [4];
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;
  logic [DW-1:0] result_q;
  logic          out_valid_q;
  logic [DW-1:0] grp;
  logic [DW-1:0] fold;
  logic          accept;
  logic          last_grp;

  assign accept   = (state_q == LOAD) && bus.in_valid;
  assign last_grp = (grp_cnt_q == LAST_GRP);

  // Reduce the staged group of four samples
  mms_cmp4 u_grp (
    .a_i   (buf_q[0]),
    .b_i   (buf_q[1]),
    .c_i   (buf_q[2]),
    .d_i   (buf_q[3]),
    .sel_i (sel_q),
    .y_o   (grp)
  );

  // Fold the group result into the running accumulator
  mms_cmp4 u_fold (
    .a_i   (acc_q),
    .b_i   (acc_q),
    .c_i   (grp),
    .d_i   (grp),
    .sel_i (sel_q),
    .y_o   (fold)
  );

  // First group seeds the accumulator; later groups fold into it
  always_comb begin
    acc_d = (grp_cnt_q == '0) ? grp : fold;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: if (accept && beat_cnt_q == 2'd3) state_d = CMP;
      CMP:  state_d = last_grp ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_valid_q;
    bus.result    = result_q;
    dbg_state_o   = state_q;
  end

  // Datapath: select latch, counters, sample buffer, accumulator, result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q       <= SEL_MAX;
      grp_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      buf_q[2]    <= '0;
      buf_q[3]    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sel_q      <= bus.sel;
            grp_cnt_q  <= '0;
            beat_cnt_q <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            buf_q[beat_cnt_q] <= bus.in_data;
            beat_cnt_q        <= beat_cnt_q + 2'd1;
          end
        end
        CMP: begin
          acc_q     <= acc_d;
          grp_cnt_q <= grp_cnt_q + GRP_W'(1);
          if (last_grp) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mms_frame_ctrl.sv
// Self-checking bench for the frame min/max sequencer.
module tb_mms_frame_ctrl;
  import mms_pkg::*;

  localparam int FL = 8;

  logic   clk;
  logic   reset;
  state_t dbg_state;

  mms_frame_ctrl_if bus ();

  mms_frame_ctrl #(.FRAME_LEN(FL), .GRP_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];
  logic [DW-1:0] smp [FL];
  logic [DW-1:0] last_result = '0;
  int            start_cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            prev_ov = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: frame extreme from plain arithmetic over the sample array
  function automatic logic [DW-1:0] ref_extreme(input logic s);
    int e;
    e = (s == SEL_MIN) ? 255 : 0;
    for (int i = 0; i < FL; i++) begin
      if (s == SEL_MIN) begin
        if (int'(smp[i]) < e) e = int'(smp[i]);
      end else begin
        if (int'(smp[i]) > e) e = int'(smp[i]);
      end
    end
    return DW'(e);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 0;
    end else begin
      if (prev_ov) check("busy_after_done", {31'd0, bus.busy}, 32'd0);
      if (bus.in_ready && !bus.busy) check("ready_outside_busy", 32'd1, 32'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          logic [DW-1:0] e;
          int lat;
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          check("result", {24'd0, bus.result}, {24'd0, e});
          if (lat >= 0) check("latency", cyc - start_cyc, lat);
          last_result = e;
        end
      end else begin
        check("result_hold", {24'd0, bus.result}, {24'd0, last_result});
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- driver ----------------
  // gap_mode: >=0 fixed idle cycles after each sample, <0 random 0..3
  // abort_after: >0 asserts reset after that many accepted samples
  task automatic run_frame(input logic s, input int gap_mode, input bit mid_start,
                           input int abort_after);
    int  t;
    int  g;
    bit  rdy;
    t = 0;
    while (bus.busy && t < 200) begin @(posedge clk); #1; t++; end
    if (bus.busy) begin check("idle_wait_timeout", 32'd1, 32'd0); return; end
    bus.start = 1'b1;
    bus.sel   = s;
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.start = 1'b0;
    exp_q.push_back(ref_extreme(s));
    lat_q.push_back((gap_mode == 0 && !mid_start) ? FL + FL / 4 : -1);
    for (int i = 0; i < FL; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = smp[i];
      if (mid_start && i == 1) begin bus.start = 1'b1; bus.sel = ~s; end
      t = 0;
      do begin
        rdy = bus.in_ready;
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 200);
      bus.start    = 1'b0;
      bus.sel      = s;
      bus.in_valid = 1'b0;
      bus.in_data  = DW'($urandom);
      if (!rdy) begin check("sample_accept_timeout", 32'd1, 32'd0); return; end
      if (abort_after > 0 && i == abort_after - 1) begin
        #2;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        last_result = '0;
        reset = 1'b1;
        #1;
        check("abort_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("abort_busy",      {31'd0, bus.busy},      32'd0);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_result",    {24'd0, bus.result},    32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (mid_start && i == 3) begin
        bus.start = 1'b1; bus.sel = ~s;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.sel = s;
      end
      g = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rand_samples(input int lo, input int hi);
    for (int i = 0; i < FL; i++) smp[i] = DW'($urandom_range(lo, hi));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.sel      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    {24'd0, bus.result},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Mixed samples, maximum then minimum, streaming without stalls
    smp = '{8'd3, 8'd200, 8'd7, 8'd9, 8'd150, 8'd1, 8'd255, 8'd0};
    run_frame(SEL_MAX, 0, 0, 0);
    run_frame(SEL_MIN, 0, 0, 0);
    // All-equal frame
    smp = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_frame(SEL_MIN, 0, 0, 0);
    // Source stalls after each sample
    smp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd5};
    run_frame(SEL_MAX, 3, 0, 0);
    // Start requests while busy (in LOAD and in CMP)
    rand_samples(0, 255);
    run_frame(SEL_MAX, 0, 1, 0);
    rand_samples(0, 255);
    run_frame(SEL_MIN, 1, 1, 0);
    // Reset after five samples, then a clean frame
    rand_samples(0, 255);
    run_frame(SEL_MAX, 0, 0, 5);
    smp = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
    run_frame(SEL_MIN, 0, 0, 0);
    // Back-to-back frames
    smp = '{8'd12, 8'd100, 8'd33, 8'd0, 8'd99, 8'd100, 8'd7, 8'd64};
    run_frame(SEL_MAX, 0, 0, 0);
    smp = '{8'd50, 8'd4, 8'd90, 8'd200, 8'd4, 8'd17, 8'd250, 8'd8};
    run_frame(SEL_MIN, 0, 0, 0);
    // Randomised frames
    for (int f = 0; f < 24; f++) begin
      if (f % 4 == 3) rand_samples(120, 130);
      else            rand_samples(0, 255);
      run_frame(1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), 0);
    end

    // Drain outstanding results
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(posedge clk); t++; end
    @(negedge clk);
    check("drain_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
